// File: rtl/operand_load_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// operand_load_ctrl_pkg
// Shared definitions for the operand load controller and its button
// conditioning sub-module.
//   state_t        : controller state (IDLE waiting for a run press,
//                    EXEC while an add is in flight)
//   DEFAULT_WIDTH  : default operand / result width in bits
//   cnt_width()    : bits needed for a counter that must hold the larger of
//                    two terminal counts
// ---------------------------------------------------------------------------
package operand_load_ctrl_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH = 16;

   // Width of a counter able to reach max(a, b) without wrapping.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/operand_load_ctrl_button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
// Conditions one active-low push-button that is asynchronous to Clk.
// The raw level passes through a two-flop synchroniser. The debounced level
// only changes after DEBOUNCE_CYCLES consecutive synchronised samples that
// disagree with it. Each 1->0 change of the debounced level produces a
// single-cycle press pulse, so a held button gives one event and a release
// gives none.
// Ports:
//   Clk    in  system clock, rising edge
//   Reset  in  asynchronous active-low reset
//   btn_n  in  raw active-low button level
//   press  out one-cycle pulse per accepted press (registered)
// ---------------------------------------------------------------------------
module button_debounce
   import operand_load_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
)
(
   input  logic Clk,
   input  logic Reset,
   input  logic btn_n,
   output logic press
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES, DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] count;

   // Two-flop synchroniser. Both flops reset to 1 so the button reads as
   // released straight out of reset.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
      end
   end

   // Debounce counter and accepted level. Any sample that agrees with the
   // accepted level restarts the count, so only an unbroken run of
   // disagreeing samples flips the level. The flip happens on the sample
   // that would take the count to DEBOUNCE_CYCLES, and the press pulse is
   // registered on that same edge.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         level <= 1'b1;
         count <= '0;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         if (sync2 == level) begin
            count <= '0;
         end else if (count == LAST) begin
            level <= sync2;
            count <= '0;
            press <= ~sync2;
         end else begin
            count <= count + ONE;
         end
      end
   end

endmodule

// File: rtl/operand_load_ctrl.sv
// ---------------------------------------------------------------------------
// operand_load_ctrl
// Front end for the adder datapath. Debounces the LoadB and Run buttons,
// captures the switch value into operand B (LoadB) or A (Run), pulses start,
// waits ADD_LATENCY cycles and then latches the adder's sum and carry.
// Optional build macro: SIGNED_OVF_EN adds the Ovf output (signed overflow
// of the captured add).
// Ports:
//   Clk        in  system clock, rising edge
//   Reset      in  asynchronous active-low reset
//   LoadB      in  active-low button, loads B from SW
//   Run        in  active-low button, loads A from SW and starts an add
//   SW         in  switch operand value
//   A, B       out operands to the adder
//   start      out one-cycle strobe, operands valid and add begins
//   Sum_in     in  adder sum
//   CO_in      in  adder carry-out
//   Result     out captured sum, held until next capture
//   Result_CO  out captured carry
//   Ovf        out captured signed overflow (SIGNED_OVF_EN only)
//   done       out one-cycle pulse coincident with Result update
//   busy       out high while an add is in flight
// ---------------------------------------------------------------------------
module operand_load_ctrl
   import operand_load_ctrl_pkg::*;
#(
   parameter int WIDTH           = DEFAULT_WIDTH,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int ADD_LATENCY     = 1
)
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             LoadB,
   input  logic             Run,
   input  logic [WIDTH-1:0] SW,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic             start,
   input  logic [WIDTH-1:0] Sum_in,
   input  logic             CO_in,
   output logic [WIDTH-1:0] Result,
   output logic             Result_CO,
`ifdef SIGNED_OVF_EN
   output logic             Ovf,
`endif
   output logic             done,
   output logic             busy
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES, ADD_LATENCY);
   localparam logic [CW-1:0] LAT = CW'(ADD_LATENCY);
   localparam logic [CW-1:0] ONE = CW'(1);

   logic          load_ev;
   logic          run_ev;
   state_t        state;
   logic [CW-1:0] cnt;

   button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_load_btn (
      .Clk   (Clk),
      .Reset (Reset),
      .btn_n (LoadB),
      .press (load_ev)
   );

   button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_run_btn (
      .Clk   (Clk),
      .Reset (Reset),
      .btn_n (Run),
      .press (run_ev)
   );

   // Controller FSM with all outputs registered.
   // B is reloaded on a LoadB press unless an add is in flight, in which case
   // the press is thrown away so the operands stay stable for the adder. A
   // run press in IDLE loads A and starts the add; since B is written in the
   // same edge, simultaneous presses make the add see the new B. In EXEC the
   // latency counter runs down and the sum is captured on the edge where it
   // reads 1, which also returns to IDLE, so start and done never overlap.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state     <= IDLE;
         cnt       <= '0;
         A         <= '0;
         B         <= '0;
         Result    <= '0;
         Result_CO <= 1'b0;
`ifdef SIGNED_OVF_EN
         Ovf       <= 1'b0;
`endif
         start     <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         start <= 1'b0;
         done  <= 1'b0;

         if (load_ev && (state != EXEC)) begin
            B <= SW;
         end

         case (state)
            IDLE: begin
               if (run_ev) begin
                  A     <= SW;
                  start <= 1'b1;
                  busy  <= 1'b1;
                  cnt   <= LAT;
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (cnt == ONE) begin
                  Result    <= Sum_in;
                  Result_CO <= CO_in;
`ifdef SIGNED_OVF_EN
                  Ovf       <= (A[WIDTH-1] == B[WIDTH-1]) &&
                               (Sum_in[WIDTH-1] != A[WIDTH-1]);
`endif
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  cnt       <= '0;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt - ONE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
